pixel_readout_ctrl: RTL

Parametrised frame controller for the pixel array: it sequences erase, exposure, ramp conversion and a row-by-row readout over N_ROWS rows. It owns the digital ramp counter that drives the shared pixel data bus during conversion, samples each row's bus word into an output FIFO with valid/ready handshake, and supports single-shot and continuous frame modes. It sits between the pixel array and the downstream image pipeline.

---
 rtl/pixel_readout_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/pixel_readout_ctrl.sv
// Frame sequencer for the pixel array: erase, expose, ramp conversion and row readout
// into a first-word-fall-through output FIFO with valid/ready handshake.
module pixel_readout_ctrl #(
  parameter int N_ROWS     = 4,
  parameter int N_COLS     = 2,
  parameter int ADC_W      = 8,
  parameter int C_ERASE    = 5,
  parameter int C_READ     = 5,
  parameter int FIFO_DEPTH = 8,
  localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1,
  localparam int BW = N_COLS * ADC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic [15:0]       exp_cycles,
  output logic              erase,
  output logic              expose,
  output logic              convert,
  output logic              ramp_en,
  output logic              bias_en,
  output logic [N_ROWS-1:0] read,
  inout  wire  [BW-1:0]     pix_bus,
  output logic [BW-1:0]     out_data,
  output logic [RW-1:0]     out_row,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [15:0]       frame_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, ERASE, EXPOSE, CONVERT, READ} state_t;

  typedef struct packed {
    logic [BW-1:0] data;
    logic [RW-1:0] row;
    logic          last;
  } entry_t;

  state_t           state;
  logic [15:0]      cnt;
  logic [15:0]      exp_lat;
  logic [ADC_W-1:0] ramp;
  logic [RW-1:0]    row;

  entry_t           mem [FIFO_DEPTH];
  logic [AW:0]      wp, rp;
  entry_t           head, wr_e;
  logic             empty, full, pop, room, push, last_row, drive;

  assign empty    = (wp == rp);
  assign full     = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop      = out_valid & out_ready;
  // a same-cycle pop frees the slot, so a full FIFO can still accept
  assign room     = ~full | pop;
  assign push     = (state == READ) && (cnt == 16'd0) && room;
  assign last_row = (row == RW'(N_ROWS - 1));
  assign wr_e     = '{data: pix_bus, row: row, last: last_row};

  assign ramp_en  = convert;
  assign bias_en  = expose;

  // ramp owns the bus except while a row is selected onto it
  assign drive = ~|read;
  for (genvar c = 0; c < N_COLS; c++) begin : g_col
    assign pix_bus[c*ADC_W +: ADC_W] = drive ? ramp : {ADC_W{1'bz}};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      erase     <= 1'b0;
      expose    <= 1'b0;
      convert   <= 1'b0;
      busy      <= 1'b0;
      read      <= '0;
      ramp      <= '0;
      cnt       <= '0;
      exp_lat   <= 16'd1;
      row       <= '0;
      frame_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          exp_lat <= (exp_cycles == 16'd0) ? 16'd1 : exp_cycles;
          state   <= ERASE;
          erase   <= 1'b1;
          busy    <= 1'b1;
          cnt     <= 16'(C_ERASE - 1);
        end
        ERASE: if (cnt == 16'd0) begin
          state  <= EXPOSE;
          erase  <= 1'b0;
          expose <= 1'b1;
          cnt    <= exp_lat - 16'd1;
        end else cnt <= cnt - 16'd1;
        EXPOSE: if (cnt == 16'd0) begin
          state   <= CONVERT;
          expose  <= 1'b0;
          convert <= 1'b1;
          ramp    <= '0;
          cnt     <= 16'((1 << ADC_W) - 1);
        end else cnt <= cnt - 16'd1;
        CONVERT: begin
          ramp <= ramp + 1'b1;
          if (cnt == 16'd0) begin
            state   <= READ;
            convert <= 1'b0;
            ramp    <= '0;
            read    <= N_ROWS'(1);
            row     <= '0;
            cnt     <= 16'(C_READ - 1);
          end else cnt <= cnt - 16'd1;
        end
        READ: begin
          if (cnt != 16'd0) cnt <= cnt - 16'd1;
          else if (push) begin
            if (last_row) begin
              frame_cnt <= frame_cnt + 16'd1;
              read      <= '0;
              row       <= '0;
              if (continuous) begin
                state <= ERASE;
                erase <= 1'b1;
                cnt   <= 16'(C_ERASE - 1);
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              row  <= row + 1'b1;
              read <= read << 1;
              cnt  <= 16'(C_READ - 1);
            end
          end
          // full FIFO: hold the row and retry the sample next cycle
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= wr_e;
  end

  assign head      = mem[rp[AW-1:0]];
  assign out_valid = ~empty;
  assign out_data  = out_valid ? head.data : '0;
  assign out_row   = out_valid ? head.row  : '0;
  assign out_last  = out_valid ? head.last : 1'b0;

endmodule
